// File: rtl/ovl_fire_pkg.sv
// Shared definitions for OVL fire collectors: record type codes and the
// checker/type to slot mapping used by every collector and its arbiter.
package ovl_fire_pkg;

    localparam logic FIRE_TYPE_2STATE = 1'b0;
    localparam logic FIRE_TYPE_XCHECK = 1'b1;

    // Slot 2i carries the 2-state fire of checker i, slot 2i+1 its X/Z fire.
    function automatic int slot_of(input int id, input logic fire_type);
        return 2 * id + int'(fire_type);
    endfunction

endpackage

// File: rtl/ovl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, searching upward modulo N.
module ovl_rr_arbiter #(
    parameter int N = 16,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);

    logic [W:0] cand;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (W + 1)'(i);
            if (cand >= (W + 1)'(N)) begin
                cand = cand - (W + 1)'(N);
            end
            if (!grant_valid && req[cand[W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[W-1:0];
            end
        end
    end

endmodule

// File: rtl/ovl_fire_collector.sv
// Collects single-cycle OVL checker fire pulses into sticky, timestamped
// pending slots and streams them out round-robin as valid/ready records.
module ovl_fire_collector
    import ovl_fire_pkg::*;
#(
    parameter int NUM_CHECKERS = 8,
    parameter int ID_W         = 3,
    parameter int TS_W         = 16,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CHECKERS-1:0] fire_2state,
    input  logic [NUM_CHECKERS-1:0] fire_xcheck,
    input  logic                    xzcheck_enable,
    input  logic                    clear,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [ID_W-1:0]         rec_id,
    output logic                    rec_type,
    output logic [TS_W-1:0]         rec_time,
    output logic [NUM_CHECKERS-1:0] pending,
    output logic [CNT_W-1:0]        total_count,
    output logic [CNT_W-1:0]        dropped_count
);

    localparam int SLOTS  = 2 * NUM_CHECKERS;
    localparam int SLOT_W = ID_W + 1;
    localparam int SUM_W  = CNT_W + SLOT_W + 1;

    logic [SLOTS-1:0]  fire_slot;
    logic [SLOTS-1:0]  pend_q;
    logic [SLOTS-1:0]  grant_hit;
    logic [SLOTS-1:0]  capture;
    logic [SLOTS-1:0]  drop;
    logic [TS_W-1:0]   ts_q [SLOTS];
    logic [TS_W-1:0]   ts_now;
    logic [SLOT_W-1:0] rr_ptr;
    logic [SLOT_W-1:0] grant_idx;
    logic              grant_valid;
    logic              load;
    logic [SLOT_W:0]   cap_pop;
    logic [SLOT_W:0]   drop_pop;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [SLOT_W:0]  b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b);
        return (sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    always_comb begin
        fire_slot = '0;
        pending   = '0;
        for (int i = 0; i < NUM_CHECKERS; i++) begin
            fire_slot[slot_of(i, FIRE_TYPE_2STATE)] = fire_2state[i];
            fire_slot[slot_of(i, FIRE_TYPE_XCHECK)] = fire_xcheck[i] & xzcheck_enable;
            pending[i] = pend_q[2*i] | pend_q[2*i+1];
        end
    end

    ovl_rr_arbiter #(
        .N (SLOTS),
        .W (SLOT_W)
    ) u_arb (
        .req         (pend_q),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A clear cycle empties the pending array, so nothing is handed out.
    assign load = !clear && (!rec_valid || rec_ready) && grant_valid;

    // A slot granted in the same cycle it fires is re-armed, not dropped.
    always_comb begin
        grant_hit = '0;
        capture   = '0;
        drop      = '0;
        cap_pop   = '0;
        drop_pop  = '0;
        for (int s = 0; s < SLOTS; s++) begin
            grant_hit[s] = load && (grant_idx == SLOT_W'(s));
            capture[s]   = !clear && fire_slot[s] && (!pend_q[s] || grant_hit[s]);
            drop[s]      = !clear && fire_slot[s] && pend_q[s] && !grant_hit[s];
            cap_pop      = cap_pop + (SLOT_W + 1)'(capture[s]);
            drop_pop     = drop_pop + (SLOT_W + 1)'(drop[s]);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from the values sampled at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_now        <= '0;
            total_count   <= '0;
            dropped_count <= '0;
        end else begin
            ts_now <= ts_now + 1'b1;
            if (clear) begin
                total_count   <= '0;
                dropped_count <= '0;
            end else begin
                total_count   <= sat_add(total_count, cap_pop);
                dropped_count <= sat_add(dropped_count, drop_pop);
            end
        end
    end

    // NOTE: the timestamp array is reset explicitly because a cleared or
    // reset slot must report a defined time; it is flop-based, not a RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                ts_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (clear) begin
                    pend_q[s] <= 1'b0;
                    ts_q[s]   <= '0;
                end else if (capture[s]) begin
                    pend_q[s] <= 1'b1;
                    ts_q[s]   <= ts_now;
                end else if (grant_hit[s]) begin
                    pend_q[s] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rec_valid <= 1'b0;
            rec_id    <= '0;
            rec_type  <= 1'b0;
            rec_time  <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            rec_valid <= 1'b1;
            rec_id    <= grant_idx[SLOT_W-1:1];
            rec_type  <= grant_idx[0];
            rec_time  <= ts_q[grant_idx];
            rr_ptr    <= (grant_idx == SLOT_W'(SLOTS - 1)) ? '0 : grant_idx + 1'b1;
        end else if (rec_ready) begin
            rec_valid <= 1'b0;
        end
    end

endmodule
